// File: rtl/scene_addr_gen.sv
// Frame-buffer address generator: maps the raster onto a down-scaled scene image in ROM,
// with frame-aligned fade-out/fade-in scene transitions and wrap-around horizontal scroll.
module scene_addr_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SCALE_SHIFT = 1,
    parameter int SCENES      = 9,
    parameter int SCENE_W     = 4,
    parameter int ADDR_W      = 20,
    parameter int FADE_MAX    = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCENE_W-1:0] state,
    input  logic [9:0]         h_cnt,
    input  logic [9:0]         v_cnt,
    input  logic               scroll_en,
    input  logic [3:0]         scroll_step,
    output logic [ADDR_W-1:0]  pixel_addr,
    output logic               valid,
    output logic [SCENE_W-1:0] scene_cur,
    output logic [3:0]         fade_level,
    output logic               busy,
    output logic               frame_start
);

    localparam int IMG_W    = H_ACTIVE >> SCALE_SHIFT;
    localparam int IMG_H    = V_ACTIVE >> SCALE_SHIFT;
    localparam int IMG_SIZE = IMG_W * IMG_H;
    localparam logic [3:0]        FADE_TOP = 4'(FADE_MAX);
    localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);

    typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [SCENE_W-1:0] target_q, target_d, scene_d;
    logic [3:0]         fade_d;
    logic [ADDR_W-1:0]  x_off_q, x_off_d, x_sum;
    logic               fb, state_ok, swap;

    logic               active_s;
    logic [ADDR_W-1:0]  xs_c, xs_s, ys_s;
    logic [SCENE_W-1:0] scene_s;

    assign fb       = (h_cnt == 10'd0) && (v_cnt == 10'(V_ACTIVE));
    assign state_ok = int'(state) < SCENES;
    assign busy     = (fsm_q != IDLE);
    assign x_sum    = x_off_q + ADDR_W'(scroll_step);

    // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        fsm_d    = fsm_q;
        target_d = target_q;
        scene_d  = scene_cur;
        fade_d   = fade_level;
        swap     = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (state_ok && state != scene_cur) begin
                    target_d = state;
                    fsm_d    = FADE_OUT;
                end
            end
            FADE_OUT: begin
                if (state_ok)
                    target_d = state;
                if (fb) begin
                    if (fade_level == 4'd0) begin
                        swap    = 1'b1;
                        scene_d = target_q;
                        fsm_d   = FADE_IN;
                    end else begin
                        fade_d = fade_level - 4'd1;
                    end
                end
            end
            FADE_IN: begin
                if (fb) begin
                    fade_d = fade_level + 4'd1;
                    if (fade_level == FADE_TOP - 4'd1)
                        fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase

        // The scene swap restarts the new image at its left edge, overriding any scroll on that fb.
        x_off_d = x_off_q;
        if (swap)
            x_off_d = '0;
        else if (fb && scroll_en)
            x_off_d = (x_sum >= IMG_W_A) ? x_sum - IMG_W_A : x_sum;

        xs_c = ADDR_W'(h_cnt >> SCALE_SHIFT) + x_off_q;
        if (xs_c >= IMG_W_A)
            xs_c = xs_c - IMG_W_A;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            target_q    <= '0;
            scene_cur   <= '0;
            fade_level  <= FADE_TOP;
            x_off_q     <= '0;
            frame_start <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            target_q    <= target_d;
            scene_cur   <= scene_d;
            fade_level  <= fade_d;
            x_off_q     <= x_off_d;
            frame_start <= fb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_s   <= 1'b0;
            xs_s       <= '0;
            ys_s       <= '0;
            scene_s    <= '0;
            pixel_addr <= '0;
            valid      <= 1'b0;
        end else begin
            active_s   <= (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
            xs_s       <= xs_c;
            ys_s       <= ADDR_W'(v_cnt >> SCALE_SHIFT);
            scene_s    <= scene_cur;
            pixel_addr <= active_s ? ADDR_W'(scene_s) * ADDR_W'(IMG_SIZE) + ys_s * IMG_W_A + xs_s
                                   : '0;
            valid      <= active_s;
        end
    end

endmodule

// File: tb/tb_scene_addr_gen.sv
// Randomised self-checking bench for scene_addr_gen against a frame-level behavioural model.
module tb_scene_addr_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  state;
    logic [9:0]  h_cnt, v_cnt;
    logic        scroll_en;
    logic [3:0]  scroll_step;
    logic [19:0] pixel_addr;
    logic        valid;
    logic [3:0]  scene_cur;
    logic [3:0]  fade_level;
    logic        busy;
    logic        frame_start;

    always #5 clk = ~clk;

    scene_addr_gen dut (
        .clk(clk), .rst(rst), .state(state), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .scroll_en(scroll_en), .scroll_step(scroll_step), .pixel_addr(pixel_addr),
        .valid(valid), .scene_cur(scene_cur), .fade_level(fade_level), .busy(busy),
        .frame_start(frame_start)
    );

    localparam int IMG_W = 320;
    localparam int IMG_SIZE = 320 * 240;

    typedef struct {bit v; int addr;} exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    // Reference model: transition phase, scenes, fade level and scroll offset at frame granularity.
    typedef enum {SHOWING, DIMMING, BRIGHTENING} phase_t;
    phase_t m_phase;
    int     m_scene, m_target, m_fade, m_xoff;
    bit     m_fs;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = SHOWING;
        m_scene  = 0;
        m_target = 0;
        m_fade   = 15;
        m_xoff   = 0;
        m_fs     = 0;
        exp_q    = {};
        exp_q.push_back('{0, 0});
    endtask

    // One pixel clock: drive raster/inputs, advance model across the edge, compare at negedge.
    task automatic tick(input int h, input int v, input int st, input bit sen, input int step);
        exp_t e;
        bit   fb;
        int   nt;
        h_cnt = 10'(h); v_cnt = 10'(v); state = 4'(st);
        scroll_en = sen; scroll_step = 4'(step);
        e.v    = (h < 640) && (v < 480);
        e.addr = e.v ? m_scene * IMG_SIZE + (v / 2) * IMG_W + ((h / 2) + m_xoff) % IMG_W : 0;
        exp_q.push_back(e);
        @(posedge clk);
        fb = (h == 0) && (v == 480);
        if (fb && sen && !(m_phase == DIMMING && m_fade == 0))
            m_xoff = (m_xoff + step) % IMG_W;
        case (m_phase)
            SHOWING:
                if (st < 9 && st != m_scene) begin
                    m_target = st;
                    m_phase  = DIMMING;
                end
            DIMMING: begin
                nt = (st < 9) ? st : m_target;
                if (fb) begin
                    if (m_fade == 0) begin
                        m_scene = m_target;
                        m_xoff  = 0;
                        m_phase = BRIGHTENING;
                    end else begin
                        m_fade--;
                    end
                end
                m_target = nt;
            end
            BRIGHTENING:
                if (fb) begin
                    m_fade++;
                    if (m_fade == 15) m_phase = SHOWING;
                end
        endcase
        m_fs = fb;
        @(negedge clk);
        e = exp_q.pop_front();
        check("pixel_addr", int'(pixel_addr), e.addr);
        check("valid", int'(valid), int'(e.v));
        check("scene_cur", int'(scene_cur), m_scene);
        check("fade_level", int'(fade_level), m_fade);
        check("busy", int'(busy), int'(m_phase != SHOWING));
        check("frame_start", int'(frame_start), int'(m_fs));
    endtask

    task automatic rand_tick(input int st, input bit sen, input int step);
        tick($urandom_range(0, 799), $urandom_range(0, 524), st, sen, step);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"}, int'(pixel_addr), 0);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_scene"}, int'(scene_cur), 0);
        check({tag, "_fade"}, int'(fade_level), 15);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_fs"}, int'(frame_start), 0);
    endtask

    initial begin
        int fbs, scene_at, done_at, st;
        bit saw_stale, sen;
        rst = 1'b1; state = '0; h_cnt = '0; v_cnt = '0; scroll_en = 1'b0; scroll_step = '0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        model_reset();

        // Basic mapping and blanking.
        tick(2, 2, 0, 0, 0);
        tick(640, 0, 0, 0, 0);
        check("addr_2_2", int'(pixel_addr), 321);
        check("valid_2_2", int'(valid), 1);
        tick(700, 500, 0, 0, 0);
        check("addr_blank", int'(pixel_addr), 0);
        check("valid_blank", int'(valid), 0);

        // Full transition to scene 3.
        tick(10, 10, 3, 0, 0);
        check("busy_rise", int'(busy), 1);
        fbs = 0; scene_at = 0; done_at = 0;
        for (int i = 0; i < 40 && done_at == 0; i++) begin
            tick(0, 480, 3, 0, 0);
            fbs++;
            if (scene_cur == 4'd3 && scene_at == 0) scene_at = fbs;
            if (!busy) done_at = fbs;
            rand_tick(3, 0, 0);
        end
        check("swap_fb", scene_at, 16);
        check("done_fb", done_at, 31);
        tick(0, 0, 3, 0, 0);
        tick(700, 500, 3, 0, 0);
        check("addr_scene3", int'(pixel_addr), 230400);

        // Retarget during fade-out: 7 then 5; 7 must never show.
        tick(5, 5, 7, 0, 0);
        saw_stale = 0; done_at = 0;
        for (int i = 0; i < 45 && done_at == 0; i++) begin
            st = (i < 4) ? 7 : 5;
            tick(0, 480, st, 0, 0);
            if (scene_cur == 4'd7) saw_stale = 1;
            if (!busy) done_at = 1;
            rand_tick(st, 0, 0);
        end
        check("retarget_done", done_at, 1);
        check("retarget_no7", int'(saw_stale), 0);
        check("retarget_scene", int'(scene_cur), 5);

        // Out-of-range request is ignored.
        for (int i = 0; i < 10; i++) rand_tick(12, 0, 0);
        check("bad_state_busy", int'(busy), 0);
        check("bad_state_scene", int'(scene_cur), 5);

        // Scroll 46 frames by 7 -> offset 2; h=636 wraps to column 0.
        for (int i = 0; i < 46; i++) tick(0, 480, 5, 1, 7);
        tick(636, 0, 5, 0, 0);
        tick(700, 500, 5, 0, 0);
        check("scroll_wrap", int'(pixel_addr), 5 * IMG_SIZE);

        // Random traffic.
        st = 5; sen = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 39) == 0) st = $urandom_range(0, 15);
            if ($urandom_range(0, 99) == 0) sen = ~sen;
            if ($urandom_range(0, 5) == 0) tick(0, 480, st, sen, $urandom_range(0, 15));
            else rand_tick(st, sen, $urandom_range(0, 15));
        end

        // Async reset in the middle of a fade-in at level 6.
        for (int i = 0; i < 60 && m_phase != SHOWING; i++) tick(0, 480, int'(scene_cur), 0, 0);
        st = (m_scene == 2) ? 4 : 2;
        tick(8, 8, st, 0, 0);
        for (int i = 0; i < 40 && !(m_phase == BRIGHTENING && m_fade == 6); i++)
            tick(0, 480, st, 0, 0);
        check("pre_rst_fade", int'(fade_level), 6);
        tick(8, 8, st, 0, 0);
        #2 rst = 1'b1;
        #1 check_reset_values("async_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) rand_tick(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
